// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding, hold-counter width and default parameters for the bus arbiter
package bus_arb_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANTED = 2'b01,
      RELEASE = 2'b10
   } arbState_t;
   localparam int CNT_W = 16;
   localparam int DEFAULT_N_REQ = 4;
   localparam int DEFAULT_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first request at or after ptr
module rr_priority_picker #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx,
   output logic         valid
);
   logic [2*N-1:0] dbl;
   logic [N-1:0] rot;
   logic [W:0] off, sum;
   always_comb begin
      dbl = {req, req} >> ptr;
      rot = dbl[N-1:0];
      off = '0;
      valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off = (W+1)'(k);
            valid = 1'b1;
         end
      end
      sum = {1'b0, ptr} + off;
      idx = W'(sum >= (W+1)'(N) ? sum - (W+1)'(N) : sum);
      grant = valid ? N'(1) << idx : '0;
   end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin single-owner bus arbiter with a turn-around cycle and a hold watchdog
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int N_REQ = DEFAULT_N_REQ,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         Bus_RQ,
   input  logic                     Bus_Ready,
   output logic [N_REQ-1:0]         Bus_GRANT,
   output logic                     Bus_Busy,
   output logic [$clog2(N_REQ)-1:0] Grant_Idx,
   output logic                     Timeout_Err
);
   localparam int IW = $clog2(N_REQ);
   arbState_t state, stateNext;
   logic [N_REQ-1:0] grantNext, pickGrant;
   logic [IW-1:0] idxNext, ptr, ptrNext, ptrAfter, pickIdx;
   logic [CNT_W-1:0] cnt, cntNext, cntInc;
   logic pickValid, ownerRq, timeoutHit, errNext;

   rr_priority_picker #(.N(N_REQ), .W(IW)) uPicker (
      .req(Bus_RQ),
      .ptr(ptr),
      .grant(pickGrant),
      .idx(pickIdx),
      .valid(pickValid)
   );

   assign ownerRq = Bus_RQ[Grant_Idx];
   assign cntInc = &cnt ? cnt : cnt + CNT_W'(1);
   assign timeoutHit = TIMEOUT_CYCLES != 0 && cntInc >= CNT_W'(TIMEOUT_CYCLES);
   assign ptrAfter = Grant_Idx == IW'(N_REQ - 1) ? '0 : Grant_Idx + IW'(1);
   assign Bus_Busy = state != IDLE;

   // A dropped request wins over a simultaneous timeout, so errNext only flags a forced release.
   always_comb begin
      stateNext = state;
      grantNext = Bus_GRANT;
      idxNext = Grant_Idx;
      ptrNext = ptr;
      cntNext = cnt;
      errNext = 1'b0;
      case (state)
         IDLE: begin
            if (pickValid) begin
               stateNext = GRANTED;
               grantNext = pickGrant;
               idxNext = pickIdx;
               cntNext = '0;
            end
         end
         GRANTED: begin
            cntNext = cntInc;
            if (!ownerRq || timeoutHit) begin
               stateNext = RELEASE;
               grantNext = '0;
               ptrNext = ptrAfter;
               errNext = ownerRq;
            end
         end
         RELEASE: stateNext = Bus_Ready ? RELEASE : IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         Bus_GRANT <= '0;
         Grant_Idx <= '0;
         ptr <= '0;
         cnt <= '0;
         Timeout_Err <= 1'b0;
      end else begin
         state <= stateNext;
         Bus_GRANT <= grantNext;
         Grant_Idx <= idxNext;
         ptr <= ptrNext;
         cnt <= cntNext;
         Timeout_Err <= errNext;
      end
   end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed stimulus with a behavioural owner/queue model checked every cycle
module tb_bus_arbiter;
   localparam int N = 4;
   localparam int TO = 8;
   logic clk, reset, ready, busy, err;
   logic [N-1:0] rq, grant;
   logic [1:0] gidx;
   int nChecks = 0, nFails = 0;

   bus_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk),
      .reset(reset),
      .Bus_RQ(rq),
      .Bus_Ready(ready),
      .Bus_GRANT(grant),
      .Bus_Busy(busy),
      .Grant_Idx(gidx),
      .Timeout_Err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic waitGrant(output int zeros);
      zeros = 0;
      for (int i = 0; i < 20 && grant == '0; i++) begin
         zeros++;
         step(1);
      end
      chk("grant_arrives", 32'(grant != '0), 1);
   endtask

   // Model: owner is -1 when nobody holds the bus; releasing marks the turn-around wait.
   int mOwner, mPtr, mIdx, mHeld;
   bit mRel, mErr, live = 0;
   always @(posedge clk) begin
      if (reset) begin
         mOwner = -1; mPtr = 0; mIdx = 0; mHeld = 0; mRel = 0; mErr = 0; live = 1;
      end else begin
         mErr = 0;
         if (mOwner >= 0) begin
            mHeld++;
            if (!rq[mOwner] || mHeld >= TO) begin
               mErr = rq[mOwner];
               mPtr = (mOwner + 1) % N;
               mOwner = -1;
               mRel = 1;
            end
         end else if (mRel) begin
            if (!ready) mRel = 0;
         end else begin
            for (int k = N - 1; k >= 0; k--)
               if (rq[(mPtr + k) % N]) mOwner = (mPtr + k) % N;
            if (mOwner >= 0) begin
               mIdx = mOwner;
               mHeld = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("model_grant", grant, mOwner >= 0 ? 32'(1) << mOwner : 0);
         chk("model_busy", busy, mOwner >= 0 || mRel);
         chk("model_idx", gidx, mIdx);
         chk("model_err", err, mErr);
         chk("onehot", 32'($countones(grant) <= 1), 1);
      end
   end

   int order[5] = '{0, 1, 2, 3, 0};
   int gap;
   initial begin
      reset = 1; rq = '0; ready = 0;
      step(2);
      reset = 0;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_idx", gidx, 0);
      chk("rst_err", err, 0);
      // single requester: grant one edge after request, release then idle
      rq = 4'b0001;
      step(1);
      chk("a_grant", grant, 4'b0001);
      chk("a_busy", busy, 1);
      step(3);
      chk("a_hold", grant, 4'b0001);
      rq = 4'b0000;
      step(1);
      chk("a_release_grant", grant, 0);
      chk("a_release_busy", busy, 1);
      step(1);
      chk("a_idle", busy, 0);
      chk("a_idx_held", gidx, 0);
      // fresh pointer, everyone requesting
      reset = 1;
      step(1);
      reset = 0;
      rq = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         waitGrant(gap);
         if (g > 0) chk("b_turnaround", 32'(gap >= 1), 1);
         chk("b_order", gidx, order[g]);
         chk("b_grant", grant, 32'(1) << order[g]);
         step(2);
         rq[order[g]] = 1'b0;
         step(1);
         chk("b_drop", grant, 0);
         rq[order[g]] = 1'b1;
      end
      rq = 4'b0000;
      step(3);
      chk("b_idle", busy, 0);
      // release held open by Bus_Ready
      ready = 1;
      rq = 4'b0010;
      waitGrant(gap);
      chk("c_grant", grant, 4'b0010);
      rq = 4'b0000;
      step(1);
      chk("c_rel_grant", grant, 0);
      rq = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("c_wait_busy", busy, 1);
         chk("c_wait_grant", grant, 0);
      end
      ready = 0;
      step(1);
      chk("c_idle_busy", busy, 0);
      chk("c_idle_grant", grant, 0);
      step(1);
      chk("c_next_grant", grant, 4'b0001);
      // watchdog: owner 0 never lets go
      rq = 4'b0101;
      step(7);
      chk("d_still_held", grant, 4'b0001);
      chk("d_no_err_yet", err, 0);
      step(1);
      chk("d_forced_drop", grant, 0);
      chk("d_err_pulse", err, 1);
      step(1);
      chk("d_err_clear", err, 0);
      step(1);
      chk("d_next_owner", grant, 4'b0100);
      chk("d_next_idx", gidx, 2);
      // reset mid-grant
      rq = 4'b0100;
      step(2);
      reset = 1;
      step(1);
      chk("e_rst_grant", grant, 0);
      chk("e_rst_busy", busy, 0);
      chk("e_rst_idx", gidx, 0);
      reset = 0;
      step(1);
      chk("e_regrant", grant, 4'b0100);
      chk("e_regrant_idx", gidx, 2);
      // owner drops on the very edge the watchdog would fire
      step(7);
      chk("f_held", grant, 4'b0100);
      rq = 4'b0000;
      step(1);
      chk("f_drop", grant, 0);
      chk("f_no_err", err, 0);
      step(3);
      chk("f_idle", busy, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (ArbitrationSubModule instances) sharing one bus; range 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum cycles one grant may be held; 0 disables the watchdog; range 0..65535.
REQ-003 Ports, listed as name  direction  width  meaning:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- Bus_RQ  in  N_REQ  per-requester bus request (one I_Bus_RQ or D_Bus_RQ per core).
- Bus_Ready  in  1  memory-side ready from the shared bus.
- Bus_GRANT  out  N_REQ  one-hot grant, registered.
- Bus_Busy  out  1  high whenever the FSM is not IDLE.
- Grant_Idx  out  clog2(N_REQ)  index of the current or last owner.
- Timeout_Err  out  1  one-cycle pulse on a forced release.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, GRANTED, RELEASE.
REQ-005 IDLE: when any Bus_RQ bit is high at an edge, the block SHALL select one requester round-robin, enter GRANTED, and drive Bus_GRANT one-hot on that same edge (1-cycle RQ-to-GRANT latency).
REQ-006 Round-robin: the search SHALL start at index ptr and wrap modulo N_REQ; ptr SHALL be 0 after reset and (owner+1) mod N_REQ after each release.
REQ-007 GRANTED: Bus_GRANT SHALL be held constant while the owner's Bus_RQ stays high; RQ changes from non-owners SHALL be ignored.
REQ-008 When the owner's Bus_RQ is low at an edge in GRANTED, the FSM SHALL enter RELEASE and Bus_GRANT SHALL be all-zero from that edge.
REQ-009 RELEASE SHALL wait until Bus_Ready is low, then enter IDLE; Bus_GRANT SHALL stay all-zero throughout.
REQ-010 Between any two grants there SHALL be at least one cycle with Bus_GRANT all-zero (bus turn-around for the high-Z hand-off).
REQ-011 Hold counter: 16 bits, cleared on entry to GRANTED, incremented each GRANTED cycle; saturates, no wrap.
REQ-012 If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES while the owner's RQ is still high, the FSM SHALL force RELEASE and pulse Timeout_Err for exactly one cycle.
REQ-013 If the owner drops RQ on the same edge the timeout is reached, the release SHALL be normal and Timeout_Err SHALL stay low.
REQ-014 Bus_GRANT SHALL never have more than one bit set.
REQ-015 Bus_Busy SHALL be high in GRANTED and RELEASE and low in IDLE.
REQ-016 Grant_Idx SHALL update when a grant is issued and hold its value through RELEASE and IDLE.

Reset
REQ-017 On reset, on the next rising clk edge: state IDLE, Bus_GRANT 0, Bus_Busy 0, Grant_Idx 0, Timeout_Err 0, ptr 0, counter 0; this SHALL hold even when reset is asserted mid-grant.
REQ-018 While reset is high, Bus_RQ and Bus_Ready SHALL be ignored.

Structure
REQ-019 Package bus_arb_pkg SHALL hold the state encoding (IDLE=2'b00, GRANTED=2'b01, RELEASE=2'b10), the counter width (16) and the default parameter values.
REQ-020 Requester selection SHALL be a separate combinational sub-module, rr_priority_picker (inputs: request vector and ptr; outputs: one-hot grant, index, valid); one instance each serves the instruction bus and the data bus.

Verification
REQ-021 Reset, then Bus_RQ=4'b0001 at cycle 2 -> Bus_GRANT=4'b0001 at cycle 3; Bus_RQ=0 at cycle 6 with Bus_Ready=0 -> GRANT 0 at cycle 7, IDLE at cycle 8.
REQ-022 Bus_RQ=4'b1111 held, each owner drops RQ after 3 granted cycles and re-raises it -> grant order 0,1,2,3,0, with at least one all-zero GRANT cycle between grants.
REQ-023 Owner releases while Bus_Ready=1 for 5 cycles -> FSM stays in RELEASE with GRANT 0 until Bus_Ready=0, and the next grant follows no earlier than 2 cycles later.
REQ-024 TIMEOUT_CYCLES=8, owner holds RQ indefinitely -> GRANT drops after 8 granted cycles, Timeout_Err high for exactly 1 cycle, and the next requester is granted.
REQ-025 Reset asserted for 1 cycle while in GRANTED with Bus_RQ=4'b0100 -> GRANT 0 and ptr 0 next edge; after reset releases, the RQ is re-granted to index 2.
